// File: rtl/shift_add_mult.sv
// Sequential radix-2 shift-add unsigned multiplier, one partial product per clock.
// Result saturates to all-ones when the full product does not fit in DataWidth bits.
module shift_add_mult #(
  parameter  int DataWidth = 8,
  localparam int CntWidth  = $clog2(DataWidth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [DataWidth-1:0] mult_a_i,
  input  logic [DataWidth-1:0] mult_b_i,
  output logic [DataWidth-1:0] value_o,
  output logic                 overflow_o,
  output logic                 done_o,
  output logic                 valid_o,
  output logic                 busy_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [2*DataWidth-1:0] a_q, a_d;
  logic [2*DataWidth-1:0] acc_q, acc_d;
  logic [DataWidth-1:0]   b_q, b_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [DataWidth-1:0]   value_q, value_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;
  logic                   valid_q, valid_d;
  logic                   acc_ovf;

  assign acc_ovf = |acc_q[2*DataWidth-1:DataWidth];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          a_d     = {{DataWidth{1'b0}}, mult_a_i};
          b_d     = mult_b_i;
          acc_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end
      S_CALC: begin
        // Fixed DataWidth steps regardless of b so latency never depends on data.
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntWidth'(DataWidth - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        ovf_d   = acc_ovf;
        value_d = acc_ovf ? {DataWidth{1'b1}} : acc_q[DataWidth-1:0];
        valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign value_o    = value_q;
  assign overflow_o = ovf_q;
  assign done_o     = done_q;
  assign valid_o    = valid_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized bench for shift_add_mult against a cycle-count/product reference model,
// plus directed operations with literal expected values.
module tb_shift_add_mult;
  localparam int DW  = 8;
  localparam int LAT = DW + 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [DW-1:0] mult_a_i = '0;
  logic [DW-1:0] mult_b_i = '0;
  logic [DW-1:0] value_o;
  logic          overflow_o, done_o, valid_o, busy_o;

  shift_add_mult #(.DataWidth(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .mult_a_i(mult_a_i), .mult_b_i(mult_b_i),
    .value_o(value_o), .overflow_o(overflow_o), .done_o(done_o),
    .valid_o(valid_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: remaining-cycle count plus the arithmetic product.
  int m_rem = 0;
  int m_prod = 0;
  int m_val = 0;
  bit m_ovf = 0, m_valid = 0, m_done = 0, m_since_rst = 1;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input int a, input int b);
    if (r) begin
      m_rem = 0; m_val = 0; m_ovf = 0; m_valid = 0; m_done = 0; m_since_rst = 1;
    end else begin
      m_done = 0;
      if (m_rem == 0 && s) begin
        m_prod = a * b;
        m_rem = LAT;
        m_valid = 0;
        m_since_rst = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done = 1;
          m_valid = 1;
          m_ovf = (m_prod > 255);
          m_val = m_ovf ? 255 : m_prod;
        end
      end
    end
  endtask

  task automatic compare();
    chk("done_o", int'(done_o), int'(m_done));
    chk("valid_o", int'(valid_o), int'(m_valid));
    chk("busy_o", int'(busy_o), int'(m_rem != 0));
    if (m_valid || m_since_rst) begin
      chk("value_o", int'(value_o), m_val);
      chk("overflow_o", int'(overflow_o), int'(m_ovf));
    end
    if (done_o) done_cnt++;
  endtask

  // One clock: drive, let the edge happen, advance model, check on the falling edge.
  task automatic cycle(input bit r, input bit s, input int a, input int b);
    rst_i = r; start_i = s; mult_a_i = DW'(a); mult_b_i = DW'(b);
    @(posedge clk_i);
    model_step(r, s, a, b);
    @(negedge clk_i);
    compare();
  endtask

  task automatic idle_rand();
    cycle(0, 0, int'($urandom_range(255)), int'($urandom_range(255)));
  endtask

  task automatic run_op(input int a, input int b, output int lat);
    cycle(0, 1, a, b);
    lat = 0;
    while (!done_o && lat < 20) begin
      idle_rand();
      lat++;
    end
  endtask

  int lat;

  initial begin
    @(negedge clk_i);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("reset value", int'(value_o), 0);
    chk("reset busy", int'(busy_o), 0);
    chk("reset valid", int'(valid_o), 0);

    run_op(3, 5, lat);
    chk("latency 3x5", lat, 9);
    chk("value 3x5", int'(value_o), 15);
    chk("ovf 3x5", int'(overflow_o), 0);
    idle_rand();
    chk("valid held", int'(valid_o), 1);
    chk("done single pulse", int'(done_o), 0);

    run_op(16, 16, lat);
    chk("value 16x16", int'(value_o), 255);
    chk("ovf 16x16", int'(overflow_o), 1);
    idle_rand();
    run_op(255, 1, lat);
    chk("value 255x1", int'(value_o), 255);
    chk("ovf 255x1", int'(overflow_o), 0);
    idle_rand();
    run_op(0, 200, lat);
    chk("latency 0x200", lat, 9);
    chk("value 0x200", int'(value_o), 0);
    idle_rand();

    // Start during CALC must be dropped.
    done_cnt = 0;
    cycle(0, 1, 2, 3);
    idle_rand();
    idle_rand();
    cycle(0, 1, 9, 9);
    repeat (14) idle_rand();
    chk("dropped start dones", done_cnt, 1);
    chk("dropped start value", int'(value_o), 6);

    // Reset at step 4 aborts the operation.
    cycle(0, 1, 7, 7);
    repeat (4) idle_rand();
    done_cnt = 0;
    cycle(1, 0, 7, 7);
    chk("abort valid", int'(valid_o), 0);
    repeat (12) idle_rand();
    chk("abort dones", done_cnt, 0);
    run_op(7, 7, lat);
    chk("restart value", int'(value_o), 49);

    // start held high: back-to-back ops, one every DW+2 cycles.
    done_cnt = 0;
    repeat (40) cycle(0, 1, int'($urandom_range(255)), int'($urandom_range(255)));
    chk("held start dones", done_cnt, 4);

    repeat (3000) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(3) == 0),
            int'($urandom_range(255)), int'($urandom_range(255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
